// File: rtl/oka_seq_mult.sv
// oka_seq_mult: time-multiplexed overlap-free Karatsuba multiplier over GF(2)[x].
// The operands are split into their even and odd coefficient halves. One shared
// H x H carry-less core computes ae*be, ao*bo and (ae^ao)*(be^bo) on three
// consecutive cycles. The three sub-products are then recombined by interleaving
// their bits, so no overlap adder is needed.
module oka_seq_mult #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-2:0] y
);

  localparam int H = (N + 1) / 2;
  localparam int W = 2 * H - 1;
  // For odd N the odd half carries only H-1 real coefficients, so ao*bo spans 2H-3 bits.
  localparam int P1W = (N % 2 == 1) ? 2 * H - 3 : W;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] MUL0 = 3'd1;
  localparam logic [2:0] MUL1 = 3'd2;
  localparam logic [2:0] MUL2 = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  logic [2:0]     state_reg;
  logic [N-1:0]   a_reg;
  logic [N-1:0]   b_reg;
  logic [W-1:0]   p0_reg;
  logic [P1W-1:0] p1_reg;
  logic [2*N-2:0] y_reg;

  logic [H-1:0]   ae;
  logic [H-1:0]   ao;
  logic [H-1:0]   be;
  logic [H-1:0]   bo;
  logic [H-1:0]   op_x;
  logic [H-1:0]   op_y;
  logic [W-1:0]   core_prod;
  logic [2*N-2:0] y_next;
  logic           accept;

  genvar gi;

  // Even/odd coefficient split; the odd half is zero-padded when N is odd.
  for (gi = 0; gi < H; gi++) begin : g_split
    assign ae[gi] = a_reg[2*gi];
    assign be[gi] = b_reg[2*gi];
    if (2 * gi + 1 < N) begin : g_odd
      assign ao[gi] = a_reg[2*gi+1];
      assign bo[gi] = b_reg[2*gi+1];
    end else begin : g_pad
      assign ao[gi] = 1'b0;
      assign bo[gi] = 1'b0;
    end
  end

  assign in_ready  = (state_reg == IDLE) | ((state_reg == DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_reg == DONE);
  assign y         = y_reg;

  // Route the sub-product operands of the current phase into the shared core.
  always_comb begin
    op_x = ae ^ ao;
    op_y = be ^ bo;
    case (state_reg)
      MUL0: begin
        op_x = ae;
        op_y = be;
      end
      MUL1: begin
        op_x = ao;
        op_y = bo;
      end
      default: ;
    endcase
  end

  // Shared carry-less schoolbook core: XOR of shifted partial rows.
  always_comb begin
    core_prod = '0;
    for (int i = 0; i < H; i++) begin
      core_prod = core_prod ^ ((W'(op_y) << i) & {W{op_x[i]}});
    end
  end

  // Overlap-free recombination. Even result bits come from P0 and P1 shifted by one
  // coefficient, odd result bits from the middle term M = P2^P0^P1 (P2 is the live
  // core output during MUL2). Terms that fall outside a sub-product are zero.
  for (gi = 0; gi < 2 * N - 1; gi++) begin : g_comb
    localparam int K = gi / 2;
    if (gi % 2 == 0) begin : g_even
      logic e_p0;
      logic e_p1;
      if (K <= W - 1) begin : g_p0
        assign e_p0 = p0_reg[K];
      end else begin : g_p0_zero
        assign e_p0 = 1'b0;
      end
      if ((K >= 1) && (K - 1 < P1W)) begin : g_p1
        assign e_p1 = p1_reg[K-1];
      end else begin : g_p1_zero
        assign e_p1 = 1'b0;
      end
      assign y_next[gi] = e_p0 ^ e_p1;
    end else begin : g_mid
      logic m_p1;
      if (K < P1W) begin : g_p1
        assign m_p1 = p1_reg[K];
      end else begin : g_p1_zero
        assign m_p1 = 1'b0;
      end
      assign y_next[gi] = core_prod[K] ^ p0_reg[K] ^ m_p1;
    end
  end

  // Sequencer: capture, three core passes, then hold the product until it is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      p0_reg    <= '0;
      p1_reg    <= '0;
      y_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            a_reg     <= a;
            b_reg     <= b;
            state_reg <= MUL0;
          end
        end
        MUL0: begin
          p0_reg    <= core_prod;
          state_reg <= MUL1;
        end
        MUL1: begin
          p1_reg    <= core_prod[P1W-1:0];
          state_reg <= MUL2;
        end
        MUL2: begin
          y_reg     <= y_next;
          state_reg <= DONE;
        end
        DONE: begin
          if (accept) begin
            a_reg     <= a;
            b_reg     <= b;
            state_reg <= MUL0;
          end else if (out_ready) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_oka_seq_mult.sv
// Bench for oka_seq_mult: three instances (N=8, N=7, N=409) share one clock and
// handshake, each seeing the low N bits of a common wide operand pair. Results
// are compared against spec constants and a shift-and-xor carry-less model.
module tb_oka_seq_mult;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         out_ready;
  logic [408:0] a_w;
  logic [408:0] b_w;

  logic         in_ready8, out_valid8;
  logic [14:0]  y8;
  logic         in_ready7, out_valid7;
  logic [12:0]  y7;
  logic         in_ready409, out_valid409;
  logic [816:0] y409;

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    int          n;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] y;
  } vec_t;

  vec_t vecs[10];

  oka_seq_mult #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8),
    .a(a_w[7:0]), .b(b_w[7:0]), .out_valid(out_valid8), .out_ready(out_ready), .y(y8)
  );

  oka_seq_mult #(.N(7)) dut7 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready7),
    .a(a_w[6:0]), .b(b_w[6:0]), .out_valid(out_valid7), .out_ready(out_ready), .y(y7)
  );

  oka_seq_mult #(.N(409)) dut409 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready409),
    .a(a_w), .b(b_w), .out_valid(out_valid409), .out_ready(out_ready), .y(y409)
  );

  always #5 clk = ~clk;

  // Reference: a(x)*b(x) over GF(2) as XOR of a shifted by each set bit of b.
  function automatic logic [816:0] clmul_ref(input logic [408:0] x, input logic [408:0] z, input int n);
    logic [816:0] acc;
    logic [816:0] xs;
    acc = '0;
    xs  = '0;
    for (int j = 0; j < n; j++) xs[j] = x[j];
    for (int i = 0; i < n; i++) begin
      if (z[i]) acc = acc ^ (xs << i);
    end
    return acc;
  endfunction

  function automatic logic [408:0] rand409();
    logic [415:0] t;
    for (int w = 0; w < 13; w++) t[w*32 +: 32] = $urandom;
    return t[408:0];
  endfunction

  task automatic check(input string name, input logic [816:0] act, input logic [816:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  // Called at the negedge right after the accepting edge; waits for the result
  // (bounded) and checks latency plus all three products against the model.
  task automatic wait_result(input logic [408:0] av, input logic [408:0] bv);
    int lat;
    lat = 0;
    while (!out_valid8 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 817'(lat), 817'(3));
    check("out_valid7", 817'(out_valid7), 817'(1));
    check("out_valid409", 817'(out_valid409), 817'(1));
    check("y8_model", 817'(y8), clmul_ref(av, bv, 8));
    check("y7_model", 817'(y7), clmul_ref(av, bv, 7));
    check("y409_model", y409, clmul_ref(av, bv, 409));
    $display("txn a=%0h b=%0h y8=%0h y7=%0h lat=%0d", av[7:0], bv[7:0], y8, y7, lat);
  endtask

  // Called at a negedge with the blocks ready; offers one pair and collects the result.
  task automatic apply_op(input logic [408:0] av, input logic [408:0] bv);
    a_w       = av;
    b_w       = bv;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    check("in_ready_offer", 817'(in_ready8), 817'(1));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_result(av, bv);
  endtask

  initial begin
    logic [408:0] qa[$];
    logic [408:0] qb[$];
    logic [408:0] xa;
    logic [408:0] xb;
    int sent, got, cyc, last_t, lat;

    vecs[0] = '{8, 16'h53, 16'hCA, 16'h3F7E};
    vecs[1] = '{8, 16'hFF, 16'hFF, 16'h5555};
    vecs[2] = '{8, 16'h80, 16'h80, 16'h4000};
    vecs[3] = '{8, 16'h00, 16'hA5, 16'h0000};
    vecs[4] = '{8, 16'h01, 16'h01, 16'h0001};
    vecs[5] = '{7, 16'h7F, 16'h7F, 16'h1555};
    vecs[6] = '{7, 16'h03, 16'h03, 16'h0005};
    vecs[7] = '{7, 16'h40, 16'h40, 16'h1000};
    vecs[8] = '{7, 16'h2A, 16'h01, 16'h002A};
    vecs[9] = '{7, 16'h20, 16'h60, 16'h0C00};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a_w       = '0;
    b_w       = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_out_valid", 817'(out_valid8), 817'(0));
    check("rst_y8", 817'(y8), 817'(0));
    check("rst_in_ready", 817'(in_ready8), 817'(1));
    check("rst_y409", y409, 817'(0));

    // Directed vectors with hand-derived products.
    for (int i = 0; i < 10; i++) begin
      apply_op(409'(vecs[i].a), 409'(vecs[i].b));
      if (vecs[i].n == 8) check($sformatf("vec%0d_y8", i), 817'(y8), 817'(vecs[i].y));
      else check($sformatf("vec%0d_y7", i), 817'(y7), 817'(vecs[i].y));
    end

    // Backpressure: hold the result for 10 cycles, busy-time offers are ignored,
    // then the next pair is taken on the same cycle out_ready rises.
    @(negedge clk);
    a_w = 409'(16'h53); b_w = 409'(16'hCA); in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    a_w = 409'(16'h11); b_w = 409'(16'h22);
    lat = 0;
    while (!out_valid8 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("bp_latency", 817'(lat), 817'(3));
    for (int k = 0; k < 10; k++) begin
      check("bp_out_valid", 817'(out_valid8), 817'(1));
      check("bp_y8", 817'(y8), 817'(16'h3F7E));
      check("bp_in_ready", 817'(in_ready8), 817'(0));
      @(negedge clk);
    end
    $display("txn backpressure hold y8=%0h", y8);
    out_ready = 1'b1;
    #1;
    check("bp_in_ready_release", 817'(in_ready8), 817'(1));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_busy_after_accept", 817'(out_valid8), 817'(0));
    wait_result(409'(16'h11), 409'(16'h22));
    check("bp_next_y8", 817'(y8), 817'(16'h0202));

    // Reset while in MUL1 aborts the operation.
    @(negedge clk);
    a_w = rand409(); b_w = rand409(); in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort_out_valid", 817'(out_valid8), 817'(0));
    check("abort_y8", 817'(y8), 817'(0));
    check("abort_in_ready", 817'(in_ready8), 817'(1));
    check("abort_y409", y409, 817'(0));
    $display("txn reset during MUL1");
    apply_op(rand409(), rand409());

    // Back-to-back random stream, in_valid and out_ready held high.
    @(negedge clk);
    sent = 0; got = 0; cyc = 0; last_t = -1;
    out_ready = 1'b1;
    while (got < 100 && cyc < 2000) begin
      if (out_valid8) begin
        if (qa.size() == 0) begin
          check("stream_unexpected_result", 817'(1), 817'(0));
        end else begin
          xa = qa.pop_front();
          xb = qb.pop_front();
          check("stream_y8", 817'(y8), clmul_ref(xa, xb, 8));
          check("stream_y7", 817'(y7), clmul_ref(xa, xb, 7));
          check("stream_y409", y409, clmul_ref(xa, xb, 409));
          if (last_t >= 0) check("stream_interval", 817'(cyc - last_t), 817'(4));
          $display("txn stream %0d a=%0h b=%0h y8=%0h", got, xa[7:0], xb[7:0], y8);
        end
        last_t = cyc;
        got++;
      end
      if (in_ready8) begin
        if (sent < 100) begin
          a_w = rand409();
          b_w = rand409();
          in_valid = 1'b1;
          qa.push_back(a_w);
          qb.push_back(b_w);
          sent++;
        end else begin
          in_valid = 1'b0;
        end
      end
      @(negedge clk);
      cyc++;
    end
    check("stream_count", 817'(got), 817'(100));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
